sdi_trs_decoder: RTL
====================

# sdi_trs_decoder

Downstream stage of the SDI receiver. It consumes the 10-bit parallel video words produced by the SDI capture stage and searches for timing reference signals (TRS preamble 3FF/000/000 followed by an XYZ word). It decodes and protection-checks the F/V/H flags, strips TRS and blanking words from the stream, and forwards only active-video samples, together with line timing, line length and a lock indication, to the packetiser.

## Interface
- VIDEO_WIDTH, 10: video word width; fixed at 10 for TRS decode.
- SAMPLE_W, 12: width of the active-sample counter and `active_len`.
- LINE_W, 11: width of `line_num`.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- video_data  in  VIDEO_WIDTH  parallel word from the capture stage.
- video_valid  in  1  word accept strobe; the block does nothing on cycles where this is 0.
- out_data  out  VIDEO_WIDTH  active-video sample.
- out_valid  out  1  `out_data` is an active sample; one-cycle strobe.
- sav  out  1  one-cycle pulse; a valid SAV XYZ word was accepted.
- eav  out  1  one-cycle pulse; a valid EAV XYZ word was accepted.
- f, v  out  1  held field and vertical-blanking flags from the last valid XYZ word.
- line_num  out  LINE_W  line counter.
- active_len  out  SAMPLE_W  active samples counted on the last completed line.
- trs_err  out  1  one-cycle pulse; preamble found but XYZ word invalid.
- locked  out  1  line timing stable.

## Operation
- Preamble FSM advances only on accepted words (`video_valid`=1). It has four states:
  - SEARCH: a 3FF word → GOT_3FF.
  - GOT_3FF: 000 → GOT_0A; 3FF → stay in GOT_3FF; any other word → SEARCH.
  - GOT_0A: 000 → GOT_0B; 3FF → GOT_3FF; any other word → SEARCH.
  - GOT_0B: the next accepted word is XYZ, whatever its value; return to SEARCH after it.
- XYZ word fields:
  - bit9 is 1.
  - bit8 = F, bit7 = V, bit6 = H.
  - bits5:2 = P3..P0, where P3 = V^H, P2 = F^H, P1 = F^V, P0 = F^V^H.
  - bits1:0 are ignored.
- If bit9 = 0 or the protection bits mismatch: pulse `trs_err`, leave `f`/`v`/active state unchanged, clear `locked`.
- Valid XYZ word:
  - Update `f` and `v`.
  - H = 0 → pulse `sav` and enter the active region.
  - H = 1 → pulse `eav` and leave the active region.
- Sample pipeline: four stages s0..s3, each holding a word plus an active tag.
  - The pipeline shifts on every accept.
  - A word's tag at entry is: in the active region AND `v` = 0 AND it is not the XYZ word itself.
  - When an EAV XYZ word is accepted, the tags of s0..s2 (its 3FF/000/000 preamble) are cleared in the same cycle.
- Output: on accept, `out_data` <= s3 word and `out_valid` <= s3 tag. With no accept, `out_valid` <= 0 and `out_data` holds.
- Sample counter:
  - Cleared at SAV.
  - Increments for each tagged word leaving s3, saturating at all-ones.
  - At EAV it is latched into `active_len`, counting only words that left s3 before the EAV's preamble.
- `line_num`:
  - Set to 1 at a valid EAV whose V = 1 while the held `v` = 0 (start of vertical blanking).
  - Incremented at every other valid EAV, saturating.
- `locked`:
  - Set at a valid EAV when the new `active_len` equals the previous nonzero `active_len`.
  - Cleared on `trs_err` or on a length mismatch at EAV.

## Timing
- Reset values: all outputs 0, FSM in SEARCH, all pipeline tags 0, not in the active region, counters 0.
- `sav`, `eav` and `trs_err` assert the cycle after the XYZ word is accepted.
- `f`, `v`, `line_num`, `active_len` and `locked` update in that same cycle.
- Sample latency: with continuous `video_valid`, a word accepted at cycle t appears on `out_data` at t+5. In general it appears one clock after the 4th subsequent accept.
- Gaps in `video_valid` freeze the FSM, pipeline and counters with no loss of state; a preamble split by gaps is still detected.
- SAV while already active (missing EAV): restart the sample counter and do not latch `active_len`.
- EAV while not active: latch `active_len` = 0 and clear `locked`.
- Reset mid-line: the next cycle has every output at 0; no `out_valid` until a new SAV is seen.

## Structure
- Shared package `sdi_pkg`:
  - TRS constants (3FF, 000).
  - Enum `trs_state_e` {SEARCH, GOT_3FF, GOT_0A, GOT_0B}.
  - XYZ field positions.
  - Function computing the P3..P0 protection bits.
- Sub-module `sdi_trs_detect` holds the preamble FSM and XYZ check. It outputs an xyz_hit strobe, F/V/H and an error strobe. The top level holds the pipeline, counters and lock logic.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with random input → all outputs 0; release → no `out_valid` before an SAV.
- Full line:
  - Stimulus: 3FF,000,000,200, then 1920 samples, then 3FF,000,000,274.
  - Required: `sav` pulse; exactly 1920 `out_valid` strobes carrying the samples in order; no 3FF/000/XYZ word ever emitted; `eav` pulse; `active_len` = 1920.
- Blanking:
  - SAV 2AC with V = 1, then 100 words → `v` = 1 and zero `out_valid`.
  - EAV 2D8 after an active line → `line_num` = 1.
- Protection error: XYZ 27C after a preamble → `trs_err` pulse, `f`/`v` unchanged, `locked` cleared.
- Lock: two consecutive 1920-sample lines → `locked` = 1 after the 2nd EAV; a third line of 1919 samples → `locked` = 0, `active_len` = 1919.
- False preamble and gaps:
  - Stream 3FF,000,3FF,000,000,200 → `sav` detected.
  - Same preamble with `video_valid` gaps of 1–3 cycles between words → identical `sav` timing relative to accepts.

Source files
------------

// File: rtl/sdi_pkg.sv
// sdi_pkg: shared TRS constants, preamble FSM states, XYZ field positions and protection helper.
package sdi_pkg;
    localparam int VIDEO_W = 10;
    localparam logic [VIDEO_W-1:0] TRS_3FF = 10'h3FF;
    localparam logic [VIDEO_W-1:0] TRS_000 = 10'h000;
    localparam int XYZ_ONE = 9;
    localparam int XYZ_F   = 8;
    localparam int XYZ_V   = 7;
    localparam int XYZ_H   = 6;
    localparam int XYZ_P3  = 5;
    localparam int XYZ_P0  = 2;
    typedef enum logic [1:0] {SEARCH, GOT_3FF, GOT_0A, GOT_0B} trs_state_e;
    function automatic logic [3:0] trs_prot(input logic f, input logic v, input logic h);
        return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction
endpackage

// File: rtl/sdi_trs_detect.sv
// sdi_trs_detect: preamble FSM over accepted words plus XYZ decode and protection check.
module sdi_trs_detect
    import sdi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VIDEO_W-1:0] data_i,
    input  logic               valid_i,
    output logic               xyz_o,
    output logic               hit_o,
    output logic               err_o,
    output logic               f_o,
    output logic               v_o,
    output logic               h_o
);
    trs_state_e state_q;
    logic       is_3ff, is_000, prot_ok;
    assign is_3ff  = data_i == TRS_3FF;
    assign is_000  = data_i == TRS_000;
    assign f_o     = data_i[XYZ_F];
    assign v_o     = data_i[XYZ_V];
    assign h_o     = data_i[XYZ_H];
    assign prot_ok = data_i[XYZ_ONE] && (data_i[XYZ_P3:XYZ_P0] == trs_prot(f_o, v_o, h_o));
    // The word after a complete preamble is the XYZ word whatever its value.
    assign xyz_o   = valid_i && (state_q == GOT_0B);
    assign hit_o   = xyz_o && prot_ok;
    assign err_o   = xyz_o && !prot_ok;
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= SEARCH;
        else if (valid_i)
            case (state_q)
                SEARCH:  state_q <= is_3ff ? GOT_3FF : SEARCH;
                GOT_3FF: state_q <= is_000 ? GOT_0A : is_3ff ? GOT_3FF : SEARCH;
                GOT_0A:  state_q <= is_000 ? GOT_0B : is_3ff ? GOT_3FF : SEARCH;
                default: state_q <= SEARCH;
            endcase
    end
endmodule

// File: rtl/sdi_trs_decoder.sv
// sdi_trs_decoder: strips TRS/blanking from the SDI word stream and forwards active samples
// with SAV/EAV pulses, F/V flags, line count, active line length and lock status.
module sdi_trs_decoder
    import sdi_pkg::*;
#(
    parameter int VIDEO_WIDTH = 10,
    parameter int SAMPLE_W    = 12,
    parameter int LINE_W      = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [VIDEO_WIDTH-1:0] video_data,
    input  logic                   video_valid,
    output logic [VIDEO_WIDTH-1:0] out_data,
    output logic                   out_valid,
    output logic                   sav,
    output logic                   eav,
    output logic                   f,
    output logic                   v,
    output logic [LINE_W-1:0]      line_num,
    output logic [SAMPLE_W-1:0]    active_len,
    output logic                   trs_err,
    output logic                   locked
);
    logic xyz, hit, err, xf, xv, xh;
    logic sav_hit, eav_hit, new_tag, leave;
    logic [3:0][VIDEO_WIDTH-1:0] word_q, word_d;
    logic [3:0]                  tag_q, tag_d;
    logic [SAMPLE_W-1:0]         cnt_q, cnt_d, cnt_inc, new_len, len_q, len_d;
    logic [LINE_W-1:0]           line_q, line_d;
    logic [VIDEO_WIDTH-1:0]      od_q, od_d;
    logic ov_q, ov_d, sav_q, sav_d, eav_q, eav_d, err_q, err_d;
    logic f_q, f_d, v_q, v_d, lock_q, lock_d, active_q, active_d;

    sdi_trs_detect u_detect (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (video_data),
        .valid_i (video_valid),
        .xyz_o   (xyz),
        .hit_o   (hit),
        .err_o   (err),
        .f_o     (xf),
        .v_o     (xv),
        .h_o     (xh)
    );

    assign sav_hit = hit && !xh;
    assign eav_hit = hit && xh;
    assign new_tag = active_q && !v_q && !xyz;
    assign leave   = video_valid && tag_q[3];
    assign cnt_inc = (leave && cnt_q != '1) ? cnt_q + SAMPLE_W'(1) : cnt_q;
    // The word leaving s3 on the EAV accept is the last sample of the line.
    assign new_len = active_q ? cnt_inc : '0;

    always_comb begin
        word_d   = video_valid ? {word_q[2:0], video_data} : word_q;
        // EAV retroactively untags its own preamble sitting in s0..s2.
        tag_d    = video_valid ? {tag_q[2:0] & ~{3{eav_hit}}, new_tag} : tag_q;
        cnt_d    = sav_hit ? '0 : cnt_inc;
        active_d = sav_hit ? 1'b1 : eav_hit ? 1'b0 : active_q;
        f_d      = hit ? xf : f_q;
        v_d      = hit ? xv : v_q;
        len_d    = eav_hit ? new_len : len_q;
        line_d   = !eav_hit ? line_q :
                   (xv && !v_q) ? LINE_W'(1) :
                   (line_q == '1) ? line_q : line_q + LINE_W'(1);
        lock_d   = err ? 1'b0 :
                   eav_hit ? (new_len == len_q && len_q != '0) : lock_q;
        od_d     = video_valid ? word_q[3] : od_q;
        ov_d     = leave;
        sav_d    = sav_hit;
        eav_d    = eav_hit;
        err_d    = err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q   <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            f_q      <= 1'b0;
            v_q      <= 1'b0;
            len_q    <= '0;
            line_q   <= '0;
            lock_q   <= 1'b0;
            od_q     <= '0;
            ov_q     <= 1'b0;
            sav_q    <= 1'b0;
            eav_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            word_q   <= word_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            f_q      <= f_d;
            v_q      <= v_d;
            len_q    <= len_d;
            line_q   <= line_d;
            lock_q   <= lock_d;
            od_q     <= od_d;
            ov_q     <= ov_d;
            sav_q    <= sav_d;
            eav_q    <= eav_d;
            err_q    <= err_d;
        end
    end

    assign out_data   = od_q;
    assign out_valid  = ov_q;
    assign sav        = sav_q;
    assign eav        = eav_q;
    assign f          = f_q;
    assign v          = v_q;
    assign line_num   = line_q;
    assign active_len = len_q;
    assign trs_err    = err_q;
    assign locked     = lock_q;
endmodule
